hazard_scheduler: RTL and testbench

- Pipeline hazard and issue scheduler for the decode stage. Tracks destination registers of instructions in flight in three registered slots (EXE, MEM, WB) that mirror the datapath.
- Drives the decode-stage Hazard input, which stalls IF/ID and injects a bubble.
- Honours memory freeze and branch flush.
- Keeps a saturating stall counter for performance debug.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_slot_pipe.sv | 41 ++++
 rtl/hazard_scheduler.sv | 144 ++++++++++++++
 tb/tb_hazard_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-stage hazard scheduler.
// A slot describes one in-flight instruction's register write-back.
package hazard_pkg;

  // Register index width carried in every slot.
  localparam int SLOT_ADDR_W = 4;

  typedef struct packed {
    logic                   valid;
    logic                   wb_en;
    logic [SLOT_ADDR_W-1:0] dest;
    logic                   is_load;
  } slot_t;

  // Forwarding select encodings for the EXE operand muxes.
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Empty slot injected on a stall, a flush or reset.
  localparam slot_t BUBBLE = '{
    valid:   1'b0,
    wb_en:   1'b0,
    dest:    {SLOT_ADDR_W{1'b0}},
    is_load: 1'b0
  };

  // True when the slot will write register r.
  function automatic logic slot_match(input slot_t s, input logic [SLOT_ADDR_W-1:0] r);
    return s.valid & s.wb_en & (s.dest == r);
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// Three-deep EXE/MEM/WB slot shift register mirroring the datapath.
// Holds everything while frozen; EXE takes a bubble on request.
module hazard_slot_pipe
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_freeze,
  input  logic  i_insert_bubble,
  input  slot_t i_new_slot,
  output slot_t o_exe,
  output slot_t o_mem,
  output slot_t o_wb
);

  slot_t r_exe;
  slot_t r_mem;
  slot_t r_wb;

  // Advance the slot pipeline one stage unless the memory freeze holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exe <= BUBBLE;
      r_mem <= BUBBLE;
      r_wb  <= BUBBLE;
    end else if (!i_freeze) begin
      r_wb  <= r_mem;
      r_mem <= r_exe;
      r_exe <= i_insert_bubble ? BUBBLE : i_new_slot;
    end else begin
      r_exe <= r_exe;
      r_mem <= r_mem;
      r_wb  <= r_wb;
    end
  end

  assign o_exe = r_exe;
  assign o_mem = r_mem;
  assign o_wb  = r_wb;

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-stage hazard and issue scheduler.
// Optional macro HAZARD_SCHEDULER_FORWARDING_EN: only load-use stalls,
// and registered forwarding selects for the EXE operands are produced.
// Without it every EXE/MEM producer stalls and the selects read 0.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int STALL_CNT_W = 16,
  parameter int REG_ADDR_W  = SLOT_ADDR_W  // must equal the slot dest width
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_src1,
  input  logic [REG_ADDR_W-1:0]  id_src2,
  input  logic                   id_two_src,
  input  logic                   id_wb_en,
  input  logic [REG_ADDR_W-1:0]  id_dest,
  input  logic                   id_mem_r_en,
  input  logic                   freeze,
  input  logic                   flush,
  output logic                   hazard,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic [1:0]             fwd_sel_a,
  output logic [1:0]             fwd_sel_b
);

  slot_t w_exe;
  slot_t w_mem;
  slot_t w_wb;
  slot_t w_new_slot;

  logic w_exe_src1;
  logic w_exe_src2;
  logic w_mem_src1;
  logic w_mem_src2;
  logic w_hazard;
  logic w_insert_bubble;
  logic w_unused;

  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_new_slot = '{
    valid:   1'b1,
    wb_en:   id_wb_en,
    dest:    id_dest,
    is_load: id_mem_r_en
  };

  hazard_slot_pipe u_slot_pipe (
    .clk             (clk),
    .rst             (rst),
    .i_freeze        (freeze),
    .i_insert_bubble (w_insert_bubble),
    .i_new_slot      (w_new_slot),
    .o_exe           (w_exe),
    .o_mem           (w_mem),
    .o_wb            (w_wb)
  );

  // Source matches against EXE and MEM; src2 only counts when it is a real operand.
  // The WB slot never matters: the register file writes before it is read.
  always_comb begin
    w_exe_src1 = slot_match(w_exe, id_src1);
    w_exe_src2 = id_two_src & slot_match(w_exe, id_src2);
    w_mem_src1 = slot_match(w_mem, id_src1);
    w_mem_src2 = id_two_src & slot_match(w_mem, id_src2);
  end

  // Hazard decision: load-use only with forwarding, any EXE/MEM producer otherwise.
  always_comb begin
`ifdef HAZARD_SCHEDULER_FORWARDING_EN
    w_hazard = (w_exe_src1 | w_exe_src2) & w_exe.is_load;
`else
    w_hazard = w_exe_src1 | w_exe_src2 | w_mem_src1 | w_mem_src2;
`endif
  end

  assign w_insert_bubble = w_hazard | flush;
  assign hazard          = w_hazard;

  // Saturating count of cycles actually lost to a hazard (freeze cycles excluded).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= {STALL_CNT_W{1'b0}};
    end else if (w_hazard && !freeze && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_count = r_stall_cnt;

`ifdef HAZARD_SCHEDULER_FORWARDING_EN
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  // Select for the ID operands as they will be seen once in EXE; EXE producer wins.
  always_comb begin
    w_fwd_a = FWD_REG;
    w_fwd_b = FWD_REG;
    if (w_exe_src1 && !w_exe.is_load) begin
      w_fwd_a = FWD_MEM;
    end else if (w_mem_src1) begin
      w_fwd_a = FWD_WB;
    end else begin
      w_fwd_a = FWD_REG;
    end
    if (w_exe_src2 && !w_exe.is_load) begin
      w_fwd_b = FWD_MEM;
    end else if (w_mem_src2) begin
      w_fwd_b = FWD_WB;
    end else begin
      w_fwd_b = FWD_REG;
    end
  end

  // Selects travel with the EXE slot: hold on freeze, clear on a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else if (!freeze) begin
      r_fwd_a <= w_insert_bubble ? FWD_REG : w_fwd_a;
      r_fwd_b <= w_insert_bubble ? FWD_REG : w_fwd_b;
    end else begin
      r_fwd_a <= r_fwd_a;
      r_fwd_b <= r_fwd_b;
    end
  end

  assign fwd_sel_a = r_fwd_a;
  assign fwd_sel_b = r_fwd_b;
`else
  assign fwd_sel_a = FWD_REG;
  assign fwd_sel_b = FWD_REG;
`endif

  // WB slot and the MEM load flag are carried for datapath symmetry only.
  assign w_unused = ^{w_wb, w_mem.is_load, w_exe.is_load};

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler; expectations follow the build's
// HAZARD_SCHEDULER_FORWARDING_EN setting.
module tb_hazard_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic        id_wb_en;
  logic [3:0]  id_dest;
  logic        id_mem_r_en;
  logic        freeze;
  logic        flush;
  logic        hazard;
  logic [15:0] stall_count;
  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;

  int n_vectors;
  int n_miscompares;
  int step;

  typedef struct packed {
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two;
    logic       wb;
    logic [3:0] dest;
    logic       ld;
  } instr_t;

  typedef struct packed {
    logic        haz;
    logic [15:0] cnt;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  exp_t exp_q[$];

  hazard_scheduler #(.STALL_CNT_W(16), .REG_ADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .id_wb_en    (id_wb_en),
    .id_dest     (id_dest),
    .id_mem_r_en (id_mem_r_en),
    .freeze      (freeze),
    .flush       (flush),
    .hazard      (hazard),
    .stall_count (stall_count),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s step %0d: got %0h expected %0h", tag, step, got, exp);
    end
  endtask

  function automatic instr_t ins(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                                 input logic wb, input logic [3:0] d, input logic ld);
    ins = '{src1: s1, src2: s2, two: two, wb: wb, dest: d, ld: ld};
  endfunction

  // One pipeline cycle: drive ID, queue the expectation, compare at the falling edge.
  task automatic cyc(input instr_t in, input logic frz, input logic fl, input logic e_haz,
                     input logic [15:0] e_cnt, input logic [1:0] e_fa, input logic [1:0] e_fb);
    exp_t e;
    id_src1     = in.src1;
    id_src2     = in.src2;
    id_two_src  = in.two;
    id_wb_en    = in.wb;
    id_dest     = in.dest;
    id_mem_r_en = in.ld;
    freeze      = frz;
    flush       = fl;
    e = '{haz: e_haz, cnt: e_cnt, fa: e_fa, fb: e_fb};
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("hazard",      32'(hazard),      32'(e.haz));
    check_eq("stall_count", 32'(stall_count), 32'(e.cnt));
    check_eq("fwd_sel_a",   32'(fwd_sel_a),   32'(e.fa));
    check_eq("fwd_sel_b",   32'(fwd_sel_b),   32'(e.fb));
    step++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic preset_count(input logic [15:0] v);
    force dut.r_stall_cnt = v;
    #1;
    release dut.r_stall_cnt;
  endtask

  instr_t nop;

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    step          = 0;
    nop           = ins(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
    id_wb_en = 1'b0; id_dest = 4'd0; id_mem_r_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    cyc(nop, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 2'd0);

`ifdef HAZARD_SCHEDULER_FORWARDING_EN
    // ADD R1 then dependent SUB: forwarded from MEM, no stall
    cyc(ins(4'd14, 4'd13, 1'b1, 1'b1, 4'd1, 1'b0), 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 2'd0);
    cyc(ins(4'd1,  4'd3,  1'b1, 1'b1, 4'd2, 1'b0), 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 2'd0);
    cyc(nop,                                      1'b0, 1'b0, 1'b0, 16'd0, 2'd1, 2'd0);
    // Independent instruction in between: forwarded from WB
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0), 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 2'd0);
    cyc(ins(4'd5,  4'd0, 1'b0, 1'b0, 4'd0, 1'b0), 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 2'd0);
    cyc(ins(4'd1,  4'd3, 1'b1, 1'b1, 4'd2, 1'b0), 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 2'd0);
    cyc(nop,                                     1'b0, 1'b0, 1'b0, 16'd0, 2'd2, 2'd0);
    // LDR R4 then ADD R5,R4: one bubble, src2=R4 ignored when single-source
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1), 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 2'd0);
    cyc(ins(4'd4,  4'd4, 1'b0, 1'b1, 4'd5, 1'b0), 1'b0, 1'b0, 1'b1, 16'd0, 2'd0, 2'd0);
    cyc(ins(4'd4,  4'd4, 1'b0, 1'b1, 4'd5, 1'b0), 1'b0, 1'b0, 1'b0, 16'd1, 2'd0, 2'd0);
    cyc(nop,                                     1'b0, 1'b0, 1'b0, 16'd1, 2'd2, 2'd0);
    // Operand 2 forwarded from MEM
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0), 1'b0, 1'b0, 1'b0, 16'd1, 2'd0, 2'd0);
    cyc(ins(4'd3,  4'd6, 1'b1, 1'b1, 4'd7, 1'b0), 1'b0, 1'b0, 1'b0, 16'd1, 2'd0, 2'd0);
    cyc(nop,                                     1'b0, 1'b0, 1'b0, 16'd1, 2'd0, 2'd1);
    // Load-use under a 3-cycle freeze
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd8, 1'b1), 1'b0, 1'b0, 1'b0, 16'd1, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(ins(4'd8, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0), 1'b1, 1'b0, 1'b1, 16'd1, 2'd0, 2'd0);
    end
    cyc(ins(4'd8, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0), 1'b0, 1'b0, 1'b1, 16'd1, 2'd0, 2'd0);
    cyc(ins(4'd8, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0), 1'b0, 1'b0, 1'b0, 16'd2, 2'd0, 2'd0);
    cyc(nop,                                     1'b0, 1'b0, 1'b0, 16'd2, 2'd2, 2'd0);
    // Flushed writer of R7 leaves nothing to forward
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0), 1'b0, 1'b1, 1'b0, 16'd2, 2'd0, 2'd0);
    cyc(ins(4'd7,  4'd0, 1'b0, 1'b1, 4'd9, 1'b0), 1'b0, 1'b0, 1'b0, 16'd2, 2'd0, 2'd0);
    cyc(nop,                                     1'b0, 1'b0, 1'b0, 16'd2, 2'd0, 2'd0);
    // Saturation from 16'hFFFE over three load-use stalls, then reset mid-stall
    preset_count(16'hFFFE);
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1), 1'b0, 1'b0, 1'b0, 16'hFFFE, 2'd0, 2'd0);
    cyc(ins(4'd1,  4'd0, 1'b0, 1'b1, 4'd2, 1'b1), 1'b0, 1'b0, 1'b1, 16'hFFFE, 2'd0, 2'd0);
    cyc(ins(4'd1,  4'd0, 1'b0, 1'b1, 4'd2, 1'b1), 1'b0, 1'b0, 1'b0, 16'hFFFF, 2'd0, 2'd0);
    cyc(ins(4'd2,  4'd0, 1'b0, 1'b1, 4'd3, 1'b1), 1'b0, 1'b0, 1'b1, 16'hFFFF, 2'd2, 2'd0);
    cyc(ins(4'd2,  4'd0, 1'b0, 1'b1, 4'd3, 1'b1), 1'b0, 1'b0, 1'b0, 16'hFFFF, 2'd0, 2'd0);
    cyc(ins(4'd3,  4'd0, 1'b0, 1'b1, 4'd11, 1'b0), 1'b0, 1'b0, 1'b1, 16'hFFFF, 2'd2, 2'd0);
    pulse_reset();
    cyc(ins(4'd3,  4'd0, 1'b0, 1'b1, 4'd11, 1'b0), 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 2'd0);
`else
    // ADD R1 then SUB R2,R1,R3: two stall cycles
    cyc(ins(4'd14, 4'd13, 1'b1, 1'b1, 4'd1, 1'b0), 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 2'd0);
    cyc(ins(4'd1,  4'd3,  1'b1, 1'b1, 4'd2, 1'b0), 1'b0, 1'b0, 1'b1, 16'd0, 2'd0, 2'd0);
    cyc(ins(4'd1,  4'd3,  1'b1, 1'b1, 4'd2, 1'b0), 1'b0, 1'b0, 1'b1, 16'd1, 2'd0, 2'd0);
    cyc(ins(4'd1,  4'd3,  1'b1, 1'b1, 4'd2, 1'b0), 1'b0, 1'b0, 1'b0, 16'd2, 2'd0, 2'd0);
    cyc(nop,                                      1'b0, 1'b0, 1'b0, 16'd2, 2'd0, 2'd0);
    // Flushed writer of R7: the following reader is free
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0), 1'b0, 1'b1, 1'b0, 16'd2, 2'd0, 2'd0);
    cyc(ins(4'd7,  4'd0, 1'b0, 1'b1, 4'd9, 1'b0), 1'b0, 1'b0, 1'b0, 16'd2, 2'd0, 2'd0);
    cyc(nop,                                     1'b0, 1'b0, 1'b0, 16'd2, 2'd0, 2'd0);
    // src2 only matters when id_two_src=1
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1), 1'b0, 1'b0, 1'b0, 16'd2, 2'd0, 2'd0);
    cyc(ins(4'd6,  4'd4, 1'b0, 1'b0, 4'd0, 1'b0), 1'b0, 1'b0, 1'b0, 16'd2, 2'd0, 2'd0);
    cyc(ins(4'd6,  4'd4, 1'b1, 1'b0, 4'd0, 1'b0), 1'b0, 1'b0, 1'b1, 16'd2, 2'd0, 2'd0);
    cyc(ins(4'd6,  4'd4, 1'b1, 1'b0, 4'd0, 1'b0), 1'b0, 1'b0, 1'b0, 16'd3, 2'd0, 2'd0);
    // Dependent waits through a 5-cycle freeze, then the countdown resumes
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0), 1'b0, 1'b0, 1'b0, 16'd3, 2'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(ins(4'd1, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0), 1'b1, 1'b0, 1'b1, 16'd3, 2'd0, 2'd0);
    end
    cyc(ins(4'd1, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0), 1'b0, 1'b0, 1'b1, 16'd3, 2'd0, 2'd0);
    cyc(ins(4'd1, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0), 1'b0, 1'b0, 1'b1, 16'd4, 2'd0, 2'd0);
    cyc(ins(4'd1, 4'd0, 1'b0, 1'b1, 4'd10, 1'b0), 1'b0, 1'b0, 1'b0, 16'd5, 2'd0, 2'd0);
    cyc(nop,                                    1'b0, 1'b0, 1'b0, 16'd5, 2'd0, 2'd0);
    // Flush together with a hazard still counts the stall
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0), 1'b0, 1'b0, 1'b0, 16'd5, 2'd0, 2'd0);
    cyc(ins(4'd3,  4'd0, 1'b0, 1'b1, 4'd12, 1'b0), 1'b0, 1'b1, 1'b1, 16'd5, 2'd0, 2'd0);
    cyc(ins(4'd3,  4'd0, 1'b0, 1'b1, 4'd12, 1'b0), 1'b0, 1'b0, 1'b1, 16'd6, 2'd0, 2'd0);
    cyc(ins(4'd3,  4'd0, 1'b0, 1'b1, 4'd12, 1'b0), 1'b0, 1'b0, 1'b0, 16'd7, 2'd0, 2'd0);
    cyc(nop,                                     1'b0, 1'b0, 1'b0, 16'd7, 2'd0, 2'd0);
    // Saturation from 16'hFFFE, then reset mid-stall
    preset_count(16'hFFFE);
    cyc(ins(4'd14, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0), 1'b0, 1'b0, 1'b0, 16'hFFFE, 2'd0, 2'd0);
    cyc(ins(4'd1,  4'd0, 1'b0, 1'b1, 4'd2, 1'b0), 1'b0, 1'b0, 1'b1, 16'hFFFE, 2'd0, 2'd0);
    cyc(ins(4'd1,  4'd0, 1'b0, 1'b1, 4'd2, 1'b0), 1'b0, 1'b0, 1'b1, 16'hFFFF, 2'd0, 2'd0);
    cyc(ins(4'd1,  4'd0, 1'b0, 1'b1, 4'd2, 1'b0), 1'b0, 1'b0, 1'b0, 16'hFFFF, 2'd0, 2'd0);
    cyc(ins(4'd2,  4'd0, 1'b0, 1'b1, 4'd11, 1'b0), 1'b0, 1'b0, 1'b1, 16'hFFFF, 2'd0, 2'd0);
    pulse_reset();
    cyc(ins(4'd2,  4'd0, 1'b0, 1'b1, 4'd11, 1'b0), 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, 2'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
